// File: rtl/prog_loader_pkg.sv
// Shared opcodes, FSM state type and default geometry for the core-array
// programming front end.
package prog_loader_pkg;

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_STREAM = 2'd1;
    localparam logic [1:0] OP_BCAST  = 2'd2;
    localparam logic [1:0] OP_CTRL   = 2'd3;

    localparam int DEF_CORES       = 8;
    localparam int DEF_LOG_CORES   = 3;
    localparam int DEF_PC_WIDTH    = 5;
    localparam int DEF_INSTR_WIDTH = 32;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // The clear request sits immediately above the mask bits of a CTRL word.
    function automatic int clr_bit_idx(input int cores);
        return cores;
    endfunction

endpackage

// File: rtl/prog_lane_reg.sv
// One core's registered write port; address and data read as zero whenever
// the lane is not writing.
module prog_lane_reg #(
    parameter int PC_WIDTH    = 5,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we_d,
    input  logic [PC_WIDTH-1:0]    addr_d,
    input  logic [INSTR_WIDTH-1:0] data_d,
    output logic                   we,
    output logic [PC_WIDTH-1:0]    addr,
    output logic [INSTR_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            we   <= we_d;
            addr <= we_d ? addr_d : '0;
            data <= we_d ? data_d : '0;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Programming front end: decodes WRITE/STREAM/BCAST/CTRL commands into
// registered per-core instruction-memory writes, including a masked memory clear.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CORES       = DEF_CORES,
    parameter int LOG_CORES   = DEF_LOG_CORES,
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [LOG_CORES-1:0]         in_sel,
    input  logic [PC_WIDTH-1:0]          in_addr,
    input  logic [INSTR_WIDTH-1:0]       in_data,
    output logic [CORES-1:0]             cwe,
    output logic [CORES*PC_WIDTH-1:0]    cwaddr,
    output logic [CORES*INSTR_WIDTH-1:0] cwdata,
    output logic                         sel_err,
    output logic                         busy
);

    localparam int CLR_BIT = clr_bit_idx(CORES);
    localparam logic [PC_WIDTH:0] DEPTH = {1'b1, {PC_WIDTH{1'b0}}};

    state_t                state, state_nx;
    logic [PC_WIDTH-1:0]   ptr, ptr_nx;
    logic [CORES-1:0]      mask, mask_nx;
    logic [PC_WIDTH:0]     cnt, cnt_nx;
    logic                  sel_err_nx;
    logic                  accept;
    logic                  sel_ok;
    logic [PC_WIDTH-1:0]   wr_addr;

    logic [CORES-1:0]                  lane_we;
    logic [CORES-1:0][PC_WIDTH-1:0]    lane_addr;
    logic [CORES-1:0][INSTR_WIDTH-1:0] lane_data;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_CLEAR);
    assign accept   = in_valid && in_ready;
    assign sel_ok   = 32'(in_sel) < CORES;
    assign wr_addr  = (in_op == OP_WRITE) ? in_addr : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            mask    <= '1;
            cnt     <= '0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            mask    <= mask_nx;
            cnt     <= cnt_nx;
            sel_err <= sel_err_nx;
        end
    end

    // cnt holds the next clear address; the first one (0) is issued from the
    // accepting CTRL cycle so the clear writes start right after acceptance.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        mask_nx    = mask;
        cnt_nx     = cnt;
        sel_err_nx = 1'b0;
        lane_we    = '0;
        lane_addr  = '0;
        lane_data  = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_WRITE, OP_STREAM: begin
                            if (sel_ok) begin
                                for (int c = 0; c < CORES; c++) begin
                                    if (32'(in_sel) == 32'(c)) begin
                                        lane_we[c]   = 1'b1;
                                        lane_addr[c] = wr_addr;
                                        lane_data[c] = in_data;
                                    end
                                end
                                ptr_nx = wr_addr + PC_WIDTH'(1);
                            end else begin
                                sel_err_nx = 1'b1;
                            end
                        end
                        OP_BCAST: begin
                            for (int c = 0; c < CORES; c++) begin
                                lane_we[c]   = mask[c];
                                lane_addr[c] = in_addr;
                                lane_data[c] = in_data;
                            end
                            ptr_nx = in_addr + PC_WIDTH'(1);
                        end
                        default: begin
                            mask_nx = in_data[CORES-1:0];
                            if (in_data[CLR_BIT]) begin
                                state_nx = ST_CLEAR;
                                cnt_nx   = (PC_WIDTH+1)'(1);
                                lane_we  = in_data[CORES-1:0];
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (cnt == DEPTH) begin
                    state_nx = ST_IDLE;
                    ptr_nx   = '0;
                    cnt_nx   = '0;
                end else begin
                    for (int c = 0; c < CORES; c++) begin
                        lane_we[c]   = mask[c];
                        lane_addr[c] = cnt[PC_WIDTH-1:0];
                    end
                    cnt_nx = cnt + (PC_WIDTH+1)'(1);
                end
            end
        endcase
    end

    for (genvar c = 0; c < CORES; c++) begin : g_lane
        prog_lane_reg #(
            .PC_WIDTH   (PC_WIDTH),
            .INSTR_WIDTH(INSTR_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we_d  (lane_we[c]),
            .addr_d(lane_addr[c]),
            .data_d(lane_data[c]),
            .we    (cwe[c]),
            .addr  (cwaddr[c*PC_WIDTH +: PC_WIDTH]),
            .data  (cwdata[c*INSTR_WIDTH +: INSTR_WIDTH])
        );
    end

endmodule
